// File: rtl/ads1675_seq_ctrl_if.sv
// ads1675_seq_ctrl_if: request/status and ADC pin bundle for the ADS1675 sequencer
`timescale 1ns/1ps
interface ads1675_seq_ctrl_if #(parameter int CW = 16);
  logic          req;
  logic [CW-1:0] burst_len;
  logic          drdy_rise;
  logic          err_clr;
  logic          pown;
  logic          start;
  logic          cs_n;
  logic [2:0]    dr;
  logic          capture_en;
  logic          busy;
  logic          done;
  logic          tmo_err;
  logic [2:0]    state_o;
  modport master (
    output req, burst_len, drdy_rise, err_clr,
    input  pown, start, cs_n, dr, capture_en, busy, done, tmo_err, state_o
  );
  modport slave (
    input  req, burst_len, drdy_rise, err_clr,
    output pown, start, cs_n, dr, capture_en, busy, done, tmo_err, state_o
  );
endinterface

// File: rtl/ads1675_seq_ctrl.sv
// ads1675_seq_ctrl: power-up, lock, restart and burst sequencing for an ADS1675 ADC
`timescale 1ns/1ps
module ads1675_seq_ctrl #(
  parameter int         PWR_WAIT  = 1024,
  parameter int         START_LOW = 16,
  parameter int         DRDY_TMO  = 4096,
  parameter int         CW        = 16,
  parameter logic [2:0] DR_CODE   = 3'b100
) (
  input logic              sclk,
  input logic              rst_n,
  ads1675_seq_ctrl_if.slave bus
);
  localparam int TM1  = PWR_WAIT > DRDY_TMO ? PWR_WAIT : DRDY_TMO;
  localparam int TMAX = TM1 > START_LOW ? TM1 : START_LOW;
  localparam int TW   = $clog2(TMAX + 1);
  typedef enum logic [2:0] {
    OFF = 3'd0, PWR_UP = 3'd1, LOCK = 3'd2, RESTART = 3'd3,
    RUN = 3'd4, READY = 3'd5, ERR = 3'd6
  } st_t;
  st_t           state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
  logic [CW-1:0] cnt_q, cnt_d, blen_q, blen_d;
  logic          pown_q, pown_d, start_q, start_d, cs_n_q, cs_n_d;
  logic          cap_q, cap_d, busy_q, busy_d, done_q, done_d, tmo_q, tmo_d;
  assign tmr_inc = &tmr_q ? tmr_q : tmr_q + TW'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blen_d  = blen_q;
    done_d  = 1'b0;
    case (state_q)
      OFF:     if (bus.req) state_d = PWR_UP;
      PWR_UP:  state_d = !bus.req ? OFF : tmr_q == TW'(PWR_WAIT - 1) ? LOCK : PWR_UP;
      LOCK:    state_d = !bus.req ? OFF : bus.drdy_rise ? RESTART :
                         tmr_q == TW'(DRDY_TMO - 1) ? ERR : LOCK;
      RESTART: if (tmr_q == TW'(START_LOW - 1)) state_d = RUN;
      RUN: begin
        cnt_d = bus.drdy_rise ? cnt_q + CW'(1) : cnt_q;
        // a sample arriving with req low still counts and may complete the burst
        if (bus.drdy_rise && blen_q != '0 && cnt_d == blen_q) begin
          state_d = READY;
          done_d  = 1'b1;
        end else if (!bus.req)
          state_d = READY;
        else if (!bus.drdy_rise && tmr_q == TW'(DRDY_TMO - 1))
          state_d = ERR;
      end
      READY:   if (bus.req) state_d = RESTART;
      ERR:     if (bus.err_clr) state_d = OFF;
      default: state_d = OFF;
    endcase
    if (state_d == RESTART && state_q != RESTART) begin
      cnt_d  = '0;
      blen_d = bus.burst_len;
    end
    tmr_d   = (state_d != state_q || (state_q == RUN && bus.drdy_rise)) ? '0 : tmr_inc;
    pown_d  = !(state_d inside {OFF, ERR});
    start_d = state_d inside {PWR_UP, LOCK, RUN};
    cs_n_d  = !pown_d;
    cap_d   = state_d == RUN;
    busy_d  = !(state_d inside {OFF, READY});
    tmo_d   = state_d == ERR;
  end
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q <= OFF;
      tmr_q   <= '0;
      cnt_q   <= '0;
      blen_q  <= '0;
      pown_q  <= 1'b0;
      start_q <= 1'b0;
      cs_n_q  <= 1'b1;
      cap_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      blen_q  <= blen_d;
      pown_q  <= pown_d;
      start_q <= start_d;
      cs_n_q  <= cs_n_d;
      cap_q   <= cap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end
  assign bus.pown       = pown_q;
  assign bus.start      = start_q;
  assign bus.cs_n       = cs_n_q;
  assign bus.dr         = DR_CODE;
  assign bus.capture_en = cap_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.tmo_err    = tmo_q;
  assign bus.state_o    = state_q;
endmodule

// File: tb/tb_ads1675_seq_ctrl.sv
// tb_ads1675_seq_ctrl: directed self-checking bench for the ADS1675 sequencer
`timescale 1ns/1ps
module tb_ads1675_seq_ctrl;
  logic sclk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n;
  int   bad;
  logic [6:0] outs;
  ads1675_seq_ctrl_if #(.CW(16)) bus ();
  ads1675_seq_ctrl #(
    .PWR_WAIT(8), .START_LOW(4), .DRDY_TMO(32), .CW(16), .DR_CODE(3'b100)
  ) dut (
    .sclk (sclk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  always #5 sclk = ~sclk;
  // pown, start, cs_n, capture_en, busy, done, tmo_err
  assign outs = {bus.pown, bus.start, bus.cs_n, bus.capture_en, bus.busy, bus.done, bus.tmo_err};
  localparam logic [6:0] O_OFF = 7'b0010000, O_PWR = 7'b1100100, O_RST = 7'b1000100,
                         O_RUN = 7'b1101100, O_DONE = 7'b1000010, O_RDY = 7'b1000000,
                         O_ERR = 7'b0010101;
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic pulse();
    bus.drdy_rise = 1'b1;
    tick();
    bus.drdy_rise = 1'b0;
  endtask
  task automatic count_state(input logic [2:0] s, output int c);
    c = 0;
    while (bus.state_o == s && c < 200) begin
      c++;
      tick();
    end
  endtask
  task automatic count_start_low(output int c);
    c = 0;
    while (!bus.start && c < 200) begin
      c++;
      tick();
    end
  endtask
  initial begin
    rst_n = 1'b0;
    bus.req = 1'b0;
    bus.burst_len = '0;
    bus.drdy_rise = 1'b0;
    bus.err_clr = 1'b0;
    repeat (2) tick();
    chk("reset_outs", outs, O_OFF);
    chk("reset_state", bus.state_o, 0);
    chk("reset_dr", bus.dr, 3'b100);
    rst_n = 1'b1;
    bus.req = 1'b1;
    bus.burst_len = 16'd3;
    tick();
    chk("pwr_outs", outs, O_PWR);
    count_state(3'd1, n);
    chk("pwr_cycles", n, 8);
    chk("lock_state", bus.state_o, 2);
    chk("lock_outs", outs, O_PWR);
    repeat (3) tick();
    pulse();
    chk("lock_discard_state", bus.state_o, 3);
    chk("restart_outs", outs, O_RST);
    bus.drdy_rise = 1'b1;
    count_start_low(n);
    bus.drdy_rise = 1'b0;
    chk("start_low_cycles", n, 4);
    chk("run_state", bus.state_o, 4);
    chk("run_outs", outs, O_RUN);
    repeat (2) begin
      repeat (9) tick();
      pulse();
      chk("run_mid_outs", outs, O_RUN);
    end
    repeat (9) tick();
    pulse();
    chk("burst_done_outs", outs, O_DONE);
    chk("burst_done_state", bus.state_o, 5);
    bus.req = 1'b0;
    tick();
    chk("ready_outs", outs, O_RDY);
    chk("ready_state", bus.state_o, 5);
    bus.req = 1'b1;
    bus.burst_len = 16'd5;
    tick();
    chk("relock_skip_state", bus.state_o, 3);
    count_start_low(n);
    chk("restart2_low_cycles", n, 4);
    chk("run2_state", bus.state_o, 4);
    repeat (3) tick();
    pulse();
    chk("run2_p1_state", bus.state_o, 4);
    repeat (3) tick();
    bus.req = 1'b0;
    pulse();
    chk("drop_req_outs", outs, O_RDY);
    chk("drop_req_state", bus.state_o, 5);
    bus.req = 1'b1;
    bus.burst_len = 16'd2;
    tick();
    chk("restart3_state", bus.state_o, 3);
    count_start_low(n);
    chk("restart3_low_cycles", n, 4);
    pulse();
    chk("run3_p1_state", bus.state_o, 4);
    repeat (2) tick();
    bus.req = 1'b0;
    pulse();
    chk("final_with_drop_outs", outs, O_DONE);
    chk("final_with_drop_state", bus.state_o, 5);
    bus.req = 1'b1;
    bus.burst_len = 16'd0;
    tick();
    count_start_low(n);
    chk("cont_run_state", bus.state_o, 4);
    bus.drdy_rise = 1'b1;
    bad = 0;
    repeat (70000) begin
      tick();
      if (bus.state_o != 3'd4 || bus.done) bad++;
    end
    bus.drdy_rise = 1'b0;
    chk("cont_bad_cycles", bad, 0);
    chk("cont_outs", outs, O_RUN);
    repeat (3) tick();
    rst_n = 1'b0;
    bus.req = 1'b0;
    tick();
    chk("midrun_reset_outs", outs, O_OFF);
    chk("midrun_reset_state", bus.state_o, 0);
    chk("midrun_reset_dr", bus.dr, 3'b100);
    rst_n = 1'b1;
    tick();
    chk("post_reset_state", bus.state_o, 0);
    bus.req = 1'b1;
    tick();
    count_state(3'd1, n);
    chk("pwr2_cycles", n, 8);
    count_state(3'd2, n);
    chk("lock_tmo_cycles", n, 32);
    chk("lock_tmo_outs", outs, O_ERR);
    chk("lock_tmo_state", bus.state_o, 6);
    repeat (3) tick();
    chk("err_ignores_req", bus.state_o, 6);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    bus.req = 1'b0;
    chk("err_clr_outs", outs, O_OFF);
    chk("err_clr_state", bus.state_o, 0);
    tick();
    bus.req = 1'b1;
    bus.burst_len = 16'd3;
    tick();
    count_state(3'd1, n);
    repeat (2) tick();
    pulse();
    count_state(3'd3, n);
    chk("run4_state", bus.state_o, 4);
    count_state(3'd4, n);
    chk("run_tmo_cycles", n, 32);
    chk("run_tmo_outs", outs, O_ERR);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
